fifo_to_aurora_tx: RTL and testbench

//  Aurora TX feeder. Drains a standard-mode FIFO (read latency 1) into the Aurora

---
 rtl/aurora_tx_pkg.sv | 24 ++
 rtl/tx_skid_fifo.sv | 65 ++++++
 rtl/fifo_to_aurora_tx.sv | 121 ++++++++++++
 tb/tb_fifo_to_aurora_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_tx_pkg.sv
// Shared types, defaults and width helpers for the Aurora TX feeder.
package aurora_tx_pkg;

   // Feeder FSM encoding.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStream = 2'd1,
      StHold   = 2'd2
   } tx_state_e;

   localparam int unsigned DefBufDepth = 4;
   localparam int unsigned DefFrameLen = 16;

   // Width able to hold the values 0..depth (buffer occupancy).
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Width able to hold the values 0..n-1 (pointers, word counter); at least 1 bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_skid_fifo.sv
// Small circular buffer between the FIFO read port and the Aurora TX stream.
// Head word is presented combinationally; it only changes on a pop.
module tx_skid_fifo
   import aurora_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BUF_DEPTH  = DefBufDepth
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_wr,
   input  logic [DATA_WIDTH-1:0]               i_wdata,
   input  logic                                i_pop,
   output logic [DATA_WIDTH-1:0]               o_head,
   output logic [occ_width(BUF_DEPTH)-1:0]     o_occ
);

   localparam int unsigned PtrW = idx_width(BUF_DEPTH);
   localparam int unsigned OccW = occ_width(BUF_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [PtrW-1:0]       r_wr_ptr;
   logic [PtrW-1:0]       r_rd_ptr;
   logic [OccW-1:0]       r_occ;
   logic [PtrW-1:0]       w_wr_ptr_nxt;
   logic [PtrW-1:0]       w_rd_ptr_nxt;

   // Pointer increment with wrap at BUF_DEPTH (depth need not be a power of two).
   always_comb begin
      w_wr_ptr_nxt = (32'(r_wr_ptr) == BUF_DEPTH - 1) ? '0 : r_wr_ptr + 1'b1;
      w_rd_ptr_nxt = (32'(r_rd_ptr) == BUF_DEPTH - 1) ? '0 : r_rd_ptr + 1'b1;
   end

   // Storage array; contents need no reset since occupancy gates the head.
   always_ff @(posedge i_clk) begin
      if (i_wr) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and occupancy; simultaneous write and pop leaves occupancy unchanged.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (i_wr) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (i_pop) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         case ({i_wr, i_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_head = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_to_aurora_tx.sv
// Drains a latency-1 FIFO into the Aurora TX AXI4-Stream port as fixed-length frames.
// Reads are issued only against guaranteed buffer room, never against tready.
module fifo_to_aurora_tx
   import aurora_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAME_LEN  = DefFrameLen,
   parameter int unsigned BUF_DEPTH  = DefBufDepth,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  user_clk,
   input  logic                  reset_TX_RX_Block,
   input  logic                  channel_up,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] s_axi_tx_tdata,
   output logic                  s_axi_tx_tvalid,
   output logic                  s_axi_tx_tlast,
   input  logic                  s_axi_tx_tready,
   output logic [CNT_WIDTH-1:0]  frames_sent,
   output logic                  tx_busy
);

   localparam int unsigned OccW = occ_width(BUF_DEPTH);
   localparam int unsigned WcW  = idx_width(FRAME_LEN);

   tx_state_e            r_state;
   tx_state_e            w_state_nxt;
   logic                 r_inflight;
   logic [WcW-1:0]       r_word_cnt;
   logic [CNT_WIDTH-1:0] r_frames;
   logic [OccW-1:0]      w_occ;
   logic                 w_room;
   logic                 w_rd_en;
   logic                 w_tvalid;
   logic                 w_tlast;
   logic                 w_pop;
   logic                 w_drained;

   // In-flight read counts against room so the buffer can never overflow.
   always_comb begin
      w_room  = (32'(w_occ) + 32'(r_inflight)) <= (BUF_DEPTH - 32'd1);
      w_rd_en = ~reset_TX_RX_Block & channel_up & ~fifo_empty & w_room;
   end

   tx_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .i_clk   (user_clk),
      .i_rst   (reset_TX_RX_Block),
      .i_wr    (r_inflight),
      .i_wdata (fifo_dout),
      .i_pop   (w_pop),
      .o_head  (s_axi_tx_tdata),
      .o_occ   (w_occ)
   );

   // Stream handshake and framing decode; tlast only ever qualified by tvalid.
   always_comb begin
      w_tvalid  = (w_occ != '0);
      w_tlast   = w_tvalid & (32'(r_word_cnt) == FRAME_LEN - 1);
      w_pop     = w_tvalid & s_axi_tx_tready;
      w_drained = (w_occ == '0) & ~r_inflight & (r_word_cnt == '0);
   end

   // Read-in-flight flag, word-in-frame counter and completed-frame counter.
   always_ff @(posedge user_clk) begin
      if (reset_TX_RX_Block) begin
         r_inflight <= 1'b0;
         r_word_cnt <= '0;
         r_frames   <= '0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_pop) begin
            if (w_tlast) begin
               r_word_cnt <= '0;
               r_frames   <= r_frames + 1'b1;
            end else begin
               r_word_cnt <= r_word_cnt + 1'b1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge user_clk) begin
      if (reset_TX_RX_Block) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; a partial frame keeps the FSM out of IDLE until it completes.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (channel_up & ~fifo_empty) w_state_nxt = StStream;
         end
         StStream: begin
            if (~channel_up)                  w_state_nxt = StHold;
            else if (fifo_empty & w_drained)  w_state_nxt = StIdle;
         end
         StHold: begin
            if (channel_up)      w_state_nxt = StStream;
            else if (w_drained)  w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign fifo_rd_en      = w_rd_en;
   assign s_axi_tx_tvalid = w_tvalid;
   assign s_axi_tx_tlast  = w_tlast;
   assign frames_sent     = r_frames;
   assign tx_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_fifo_to_aurora_tx.sv
// Directed bench for fifo_to_aurora_tx: a default instance (FRAME_LEN=16) and a
// FRAME_LEN=1 / 2-bit counter instance used for per-word tlast and counter wrap.
module tb_fifo_to_aurora_tx;

   logic user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   logic reset_TX_RX_Block = 1'b1;
   logic channel_up        = 1'b1;
   logic s_axi_tx_tready   = 1'b1;
   logic rnd_ready         = 1'b0;

   logic [31:0] fifo_dout0  = '0;
   logic        fifo_empty0 = 1'b1;
   logic        fifo_rd_en0;
   logic [31:0] tdata0;
   logic        tvalid0;
   logic        tlast0;
   logic [15:0] frames0;
   logic        busy0;

   logic [31:0] fifo_dout1  = '0;
   logic        fifo_empty1 = 1'b1;
   logic        fifo_rd_en1;
   logic [31:0] tdata1;
   logic        tvalid1;
   logic        tlast1;
   logic [1:0]  frames1;
   logic        busy1;

   fifo_to_aurora_tx #(
      .DATA_WIDTH (32),
      .FRAME_LEN  (16),
      .BUF_DEPTH  (4),
      .CNT_WIDTH  (16)
   ) u_dut0 (
      .user_clk          (user_clk),
      .reset_TX_RX_Block (reset_TX_RX_Block),
      .channel_up        (channel_up),
      .fifo_dout         (fifo_dout0),
      .fifo_empty        (fifo_empty0),
      .fifo_rd_en        (fifo_rd_en0),
      .s_axi_tx_tdata    (tdata0),
      .s_axi_tx_tvalid   (tvalid0),
      .s_axi_tx_tlast    (tlast0),
      .s_axi_tx_tready   (s_axi_tx_tready),
      .frames_sent       (frames0),
      .tx_busy           (busy0)
   );

   fifo_to_aurora_tx #(
      .DATA_WIDTH (32),
      .FRAME_LEN  (1),
      .BUF_DEPTH  (3),
      .CNT_WIDTH  (2)
   ) u_dut1 (
      .user_clk          (user_clk),
      .reset_TX_RX_Block (reset_TX_RX_Block),
      .channel_up        (channel_up),
      .fifo_dout         (fifo_dout1),
      .fifo_empty        (fifo_empty1),
      .fifo_rd_en        (fifo_rd_en1),
      .s_axi_tx_tdata    (tdata1),
      .s_axi_tx_tvalid   (tvalid1),
      .s_axi_tx_tlast    (tlast1),
      .s_axi_tx_tready   (s_axi_tx_tready),
      .frames_sent       (frames1),
      .tx_busy           (busy1)
   );

   // Source FIFO models: read latency 1, registered empty flag.
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always @(posedge user_clk) begin
      if (fifo_rd_en0 && q0.size() > 0) fifo_dout0 <= q0.pop_front();
      fifo_empty0 <= (q0.size() == 0);
      if (fifo_rd_en1 && q1.size() > 0) fifo_dout1 <= q1.pop_front();
      fifo_empty1 <= (q1.size() == 0);
   end

   // Sink monitors: record every handshake and count AXI stability violations.
   logic [31:0] rcv0_data[$];
   logic        rcv0_last[$];
   int unsigned rcv0_cyc[$];
   logic [31:0] rcv1_data[$];
   logic        rcv1_last[$];
   int unsigned cyc_cnt    = 0;
   int unsigned stab_err   = 0;
   logic        prev_hold  = 1'b0;
   logic [33:0] prev_bundle = '0;

   always @(posedge user_clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (reset_TX_RX_Block) begin
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold && ({tvalid0, tlast0, tdata0} != prev_bundle)) stab_err <= stab_err + 1;
         prev_hold   <= tvalid0 & ~s_axi_tx_tready;
         prev_bundle <= {tvalid0, tlast0, tdata0};
         if (tvalid0 && s_axi_tx_tready) begin
            rcv0_data.push_back(tdata0);
            rcv0_last.push_back(tlast0);
            rcv0_cyc.push_back(cyc_cnt);
         end
         if (tvalid1 && s_axi_tx_tready) begin
            rcv1_data.push_back(tdata1);
            rcv1_last.push_back(tlast1);
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge user_clk);
      #1;
      if (rnd_ready) s_axi_tx_tready = 1'($urandom_range(0, 1));
   endtask

   function automatic int pop_count(input int sel);
      return (sel == 0) ? rcv0_data.size() : rcv1_data.size();
   endfunction

   task automatic wait_pops(input int sel, input int n, input int budget, input string tag);
      int k = 0;
      while (pop_count(sel) < n && k < budget) begin
         step();
         k++;
      end
      check(tag, 64'(pop_count(sel)), 64'(n));
   endtask

   task automatic clear_rcv();
      rcv0_data.delete();
      rcv0_last.delete();
      rcv0_cyc.delete();
      rcv1_data.delete();
      rcv1_last.delete();
   endtask

   logic [31:0] exp_q[$];
   int          n_rem;

   initial begin
      // 1: reset held with data available and channel up; everything stays quiet.
      for (int i = 0; i < 32; i++) q0.push_back(32'(i));
      repeat (5) begin
         @(negedge user_clk);
         check("t1_reset_outputs",
               64'({fifo_rd_en0, tvalid0, tlast0, busy0, frames0, tdata0}), 64'd0);
      end
      @(posedge user_clk);
      #1 reset_TX_RX_Block = 1'b0;
      @(negedge user_clk);
      check("t1_first_rd_en", 64'(fifo_rd_en0), 64'd1);
      check("t1_tvalid_c0", 64'(tvalid0), 64'd0);
      @(negedge user_clk);
      check("t1_tvalid_c1", 64'(tvalid0), 64'd0);
      @(negedge user_clk);
      check("t1_tvalid_c2", 64'(tvalid0), 64'd1);
      check("t1_first_data", 64'(tdata0), 64'd0);

      // 2: 32 words at full rate, two frames.
      wait_pops(0, 32, 200, "t2_pop_count");
      for (int i = 0; i < 32; i++)
         check("t2_word", 64'({rcv0_last[i], rcv0_data[i]}), 64'({(i % 16 == 15), 32'(i)}));
      check("t2_no_bubble", 64'(rcv0_cyc[31] - rcv0_cyc[0]), 64'd31);
      repeat (4) step();
      @(negedge user_clk);
      check("t2_frames_sent", 64'(frames0), 64'd2);
      check("t2_idle", 64'(busy0), 64'd0);

      // 3: same words under random backpressure.
      step();
      clear_rcv();
      for (int i = 0; i < 32; i++) q0.push_back(32'(i));
      rnd_ready = 1'b1;
      wait_pops(0, 32, 600, "t3_pop_count");
      rnd_ready       = 1'b0;
      s_axi_tx_tready = 1'b1;
      for (int i = 0; i < 32; i++)
         check("t3_word", 64'({rcv0_last[i], rcv0_data[i]}), 64'({(i % 16 == 15), 32'(i)}));
      repeat (4) step();
      @(negedge user_clk);
      check("t3_frames_sent", 64'(frames0), 64'd4);
      check("t3_axi_stable", 64'(stab_err), 64'd0);

      // 4: channel_up drops mid-frame, frame resumes when it returns.
      step();
      clear_rcv();
      for (int i = 0; i < 16; i++) q0.push_back(32'(200 + i));
      wait_pops(0, 6, 100, "t4_pre_drop");
      channel_up = 1'b0;
      @(negedge user_clk);
      check("t4_rd_en_off", 64'(fifo_rd_en0), 64'd0);
      repeat (8) step();
      @(negedge user_clk);
      check("t4_hold_tvalid", 64'(tvalid0), 64'd0);
      check("t4_hold_busy", 64'(busy0), 64'd1);
      check("t4_hold_rd_en", 64'(fifo_rd_en0), 64'd0);
      check("t4_no_loss", 64'(rcv0_data.size() + q0.size()), 64'd16);
      check("t4_partial", 64'(rcv0_data.size() < 16), 64'd1);
      step();
      channel_up = 1'b1;
      wait_pops(0, 16, 200, "t4_pop_count");
      for (int i = 0; i < 16; i++)
         check("t4_word", 64'({rcv0_last[i], rcv0_data[i]}), 64'({(i == 15), 32'(200 + i)}));
      repeat (4) step();
      @(negedge user_clk);
      check("t4_frames_sent", 64'(frames0), 64'd5);
      check("t4_idle", 64'(busy0), 64'd0);

      // 6: reset with a full buffer mid-frame; next word opens a new frame.
      step();
      clear_rcv();
      for (int i = 0; i < 8; i++) q0.push_back(32'(300 + i));
      wait_pops(0, 2, 100, "t6_pre_stall");
      s_axi_tx_tready = 1'b0;
      repeat (8) step();
      @(negedge user_clk);
      check("t6_stalled_valid", 64'(tvalid0), 64'd1);
      step();
      reset_TX_RX_Block = 1'b1;
      @(negedge user_clk);
      check("t6_rd_en_gated", 64'(fifo_rd_en0), 64'd0);
      @(negedge user_clk);
      check("t6_after_reset", 64'({tvalid0, tlast0, busy0, frames0}), 64'd0);
      step();
      clear_rcv();
      exp_q = q0;
      n_rem = q0.size();
      for (int k = 0; k < 16 - n_rem; k++) begin
         q0.push_back(32'(400 + k));
         exp_q.push_back(32'(400 + k));
      end
      reset_TX_RX_Block = 1'b0;
      s_axi_tx_tready   = 1'b1;
      wait_pops(0, 16, 200, "t6_pop_count");
      for (int i = 0; i < 16; i++)
         check("t6_word", 64'({rcv0_last[i], rcv0_data[i]}), 64'({(i == 15), exp_q[i]}));
      repeat (4) step();
      @(negedge user_clk);
      check("t6_frames_sent", 64'(frames0), 64'd1);

      // 5: FRAME_LEN=1 instance, tlast per word and 2-bit counter wrap.
      step();
      clear_rcv();
      for (int i = 0; i < 3; i++) q1.push_back(32'(500 + i));
      wait_pops(1, 3, 100, "t5_pop_count_a");
      for (int i = 0; i < 3; i++)
         check("t5_word", 64'({rcv1_last[i], rcv1_data[i]}), 64'({1'b1, 32'(500 + i)}));
      repeat (4) step();
      @(negedge user_clk);
      check("t5_frames_3", 64'(frames1), 64'd3);
      step();
      q1.push_back(32'd503);
      wait_pops(1, 4, 100, "t5_pop_count_b");
      check("t5_word_last", 64'({rcv1_last[3], rcv1_data[3]}), 64'({1'b1, 32'd503}));
      repeat (4) step();
      @(negedge user_clk);
      check("t5_frames_wrap", 64'(frames1), 64'd0);
      check("t5_idle", 64'(busy1), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
